// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int csa_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk-index counter width; never narrower than one bit.
  function automatic int csa_idx_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// CHUNK-bit combinational ripple-carry adder slice: {o_cout,o_s} = i_a + i_b + i_cin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module csa_chunk_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);

  logic w_carry;

  // Bit-serial ripple through the slice, LSB first.
  always_comb begin
    w_carry = i_cin;
    o_s     = '0;
    for (int i = 0; i < W; i++) begin
      o_s[i]  = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder summing CHUNK bits per clock; CSA_SUB_EN adds a subtract port.
// Latency: start accepted at edge E0 -> done pulses in the cycle after edge E0+NCHUNK.
// Backpressure: start only taken in IDLE or DONE; start during RUN is dropped, not queued.
module chunked_seq_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NCHUNK = csa_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = csa_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
    $fatal(1, "chunked_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  csa_state_t       r_state;
  csa_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [CHUNK-1:0] w_chunk_s;
  logic             w_chunk_c;
  logic [WIDTH-1:0] w_res_nxt;

  // Subtraction is a + ~b + ~cin, so only the captured B and carry change.
`ifdef CSA_SUB_EN
  assign w_b_in   = sub ? ~b   : b;
  assign w_cin_in = sub ? ~cin : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  assign w_accept  = start && (r_state == IDLE || r_state == DONE);
  assign w_last    = (r_idx == LAST_IDX);
  assign w_chunk_a = r_a[r_idx*CHUNK +: CHUNK];
  assign w_chunk_b = r_b[r_idx*CHUNK +: CHUNK];

  csa_chunk_add #(.W(CHUNK)) u_chunk_add (
    .i_a    (w_chunk_a),
    .i_b    (w_chunk_b),
    .i_cin  (r_carry),
    .o_s    (w_chunk_s),
    .o_cout (w_chunk_c)
  );

  // Result with the current chunk slotted in; this is the final sum on the last RUN edge.
  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[r_idx*CHUNK +: CHUNK] = w_chunk_s;
  end

  // Next-state decode: DONE with start goes straight back to RUN (no idle bubble).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, per-chunk accumulation and final result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_res   <= w_res_nxt;
      r_carry <= w_chunk_c;
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
      if (w_last) begin
        r_s    <= w_res_nxt;
        r_cout <= w_chunk_c;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder: directed corner cases plus random traffic.
// Expected {cout,s} and completion cycle are queued at issue; a negedge monitor checks them.
// Works with or without CSA_SUB_EN defined.
module tb_chunked_seq_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CSA_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
`ifdef CSA_SUB_EN
  logic             sub   = 1'b0;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

  chunked_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CSA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    int               cyc;
    string            name;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  int               checks = 0;
  int               passed = 0;
  logic [WIDTH-1:0] hold_s = '0;
  logic             hold_c = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer arithmetic on the operands as issued.
  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic c, input logic sb);
    logic [63:0] ax, by, cc, r;
    ax = 64'(x);
    by = 64'(y);
    cc = 64'(c);
    if (sb) begin
      r = ax - by - cc;
      return {(ax >= by + cc), r[WIDTH-1:0]};
    end
    r = ax + by + cc;
    return r[WIDTH:0];
  endfunction

  // Caller sits #1 after a posedge with the DUT in IDLE or DONE.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic sb, input string nm);
    logic [WIDTH:0] r;
    a = x; b = y; cin = c; start = 1'b1;
`ifdef CSA_SUB_EN
    sub = sb;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
`ifdef CSA_SUB_EN
    sub = 1'($urandom_range(0, 1));
`endif
    r = ref_op(x, y, c, sb & HAS_SUB);
    q.push_back('{r[WIDTH-1:0], r[WIDTH], cyc + NCHUNK, nm});
    check({nm, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: done still 0 after %0d cycles, expected 1", nm, n);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pop and compare on every done; otherwise results must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = q.pop_front();
          check({e.name, "_s"}, 64'(s), 64'(e.s));
          check({e.name, "_cout"}, 64'(cout), 64'(e.cout));
          check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
          check({e.name, "_busy_in_done"}, 64'(busy), 64'd0);
          hold_s = e.s;
          hold_c = e.cout;
        end
      end else begin
        check("hold_s", 64'(s), 64'(hold_s));
        check("hold_cout", 64'(cout), 64'(hold_c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] x, y;
    logic             c, sb;
    int               gap;

    // Reset state.
    idle_cycles(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    // All-ones plus one: full carry ripple across every chunk.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "carry_all");
    wait_done("carry_all");
    idle_cycles(1);

    // Mixed operands with cin; extra start pulse mid-run must be ignored.
    issue(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, "mix_cin");
    idle_cycles(1);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    idle_cycles(1);
    start = 1'b0;
    wait_done("mix_cin");

    // Back-to-back: start held in the DONE cycle.
    issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, "b2b");
    wait_done("b2b");
    idle_cycles(1);

    // Reset after two RUN edges: everything clears, no done follows.
    issue(32'hCAFE_0000, 32'h0000_BABE, 1'b1, 1'b0, "rst_mid");
    idle_cycles(2);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_s", 64'(s), 64'd0);
    check("rst_mid_cout", 64'(cout), 64'd0);
    q.delete();
    hold_s = '0;
    hold_c = 1'b0;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(NCHUNK + 3);

`ifdef CSA_SUB_EN
    issue(32'd5, 32'd7, 1'b0, 1'b1, "sub_neg");
    wait_done("sub_neg");
    idle_cycles(1);
    issue(32'd7, 32'd5, 1'b0, 1'b1, "sub_pos");
    wait_done("sub_pos");
    idle_cycles(1);
`endif

    // Random traffic with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      x  = $urandom;
      y  = $urandom;
      if ($urandom_range(0, 4) == 0) x = '1;
      if ($urandom_range(0, 4) == 0) y = '0;
      c  = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      issue(x, y, c, sb, "rand");
      wait_done("rand");
      gap = $urandom_range(0, 3);
      idle_cycles(gap);
    end

    idle_cycles(NCHUNK + 4);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
